fp_round_pack: RTL and testbench

- Downstream stage of the fixed-point normalizer.
- Consumes a normalized 16-bit magnitude (leading one at bit 15) plus the leading-bit position, and produces an IEEE-754 binary16 word.
- Rounding is round-to-nearest-even.
- 2-stage pipeline with valid/ready handshake on both sides, so it can be stalled by the consumer.

---
 rtl/fp_pack_pkg.sv | 36 +++
 rtl/fp_round_pack_if.sv | 32 +++
 rtl/fp_rne_round.sv | 26 ++
 rtl/fp_round_pack.sv | 102 ++++++++++
 tb/tb_fp_round_pack.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pack_pkg.sv
// fp_pack_pkg: shared constants and the stage-1 record for fp_round_pack.
//   EXP_BIAS/EXP_MAX    : binary16 exponent bias and the first exponent code
//                         that no longer encodes a finite value.
//   FP16_INF/FP16_MAXF  : unsigned magnitude of infinity and of the largest
//                         finite value.
//   s1_t                : fields captured by stage 1 (pre-rounding).
//   s2_t                : packed result captured by stage 2.
package fp_pack_pkg;

    localparam int DATA_W   = 16;
    localparam int LEAD_W   = 4;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;

    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [EXP_W:0]    exp_pre;   // one spare bit so the carry can exceed 30
        logic [MANT_W-1:0] frac_pre;
        logic              guard;
        logic              sticky;
        logic              round_up;
    } s1_t;

    typedef struct packed {
        logic [15:0] fp;
        logic        inexact;
        logic        ovf;
    } s2_t;

endpackage

// File: rtl/fp_round_pack_if.sv
// fp_round_pack_if: input and output handshakes of fp_round_pack.
//   Input side : valid_i, ready_o, sign_i, norm_data_i, leading_bit_i.
//   Output side: valid_o, ready_i, fp_data_o, inexact_o, ovf_o.
//   Handshake  : a word moves on a side in any cycle where its valid and
//                ready are both high at the rising edge; a producer holding
//                valid high keeps its data stable until that happens.
//   Modports   : slave = the rounding block, master = whoever drives it.
interface fp_round_pack_if
    import fp_pack_pkg::*;
    ;
    logic              valid_i;
    logic              ready_o;
    logic              sign_i;
    logic [DATA_W-1:0] norm_data_i;
    logic [LEAD_W-1:0] leading_bit_i;
    logic              valid_o;
    logic              ready_i;
    logic [15:0]       fp_data_o;
    logic              inexact_o;
    logic              ovf_o;

    modport slave (
        input  valid_i, sign_i, norm_data_i, leading_bit_i, ready_i,
        output ready_o, valid_o, fp_data_o, inexact_o, ovf_o
    );

    modport master (
        output valid_i, sign_i, norm_data_i, leading_bit_i, ready_i,
        input  ready_o, valid_o, fp_data_o, inexact_o, ovf_o
    );

endinterface

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational increment of the fraction by the precomputed
// round-to-nearest-even decision, with the exponent bumped on fraction carry.
//   frac_pre_i : 10-bit fraction before rounding
//   round_up_i : 1 when the discarded bits demand an increment
//   exp_pre_i  : biased exponent before rounding (6-bit)
//   frac_o     : rounded fraction
//   exp_o      : biased exponent after carry (may reach 31)
module fp_rne_round
    import fp_pack_pkg::*;
(
    input  logic [MANT_W-1:0] frac_pre_i,
    input  logic              round_up_i,
    input  logic [EXP_W:0]    exp_pre_i,
    output logic [MANT_W-1:0] frac_o,
    output logic [EXP_W:0]    exp_o
);

    logic [MANT_W:0] sum;

    // A carry out means 1.111..1 rolled to 10.000..0: fraction wraps to zero
    // and the exponent absorbs the extra power of two.
    assign sum    = {1'b0, frac_pre_i} + {{MANT_W{1'b0}}, round_up_i};
    assign frac_o = sum[MANT_W-1:0];
    assign exp_o  = exp_pre_i + {{EXP_W{1'b0}}, sum[MANT_W]};

endmodule

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalized 16-bit magnitude to IEEE-754 binary16
// (round-to-nearest-even) in a two-stage valid/ready pipeline.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : fp_round_pack_if.slave (input word + output word handshakes)
// Build option FP_PACK_SAT_EN: overflow yields the signed largest finite
// value instead of signed infinity; ovf_o is raised either way.
module fp_round_pack
    import fp_pack_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fp_round_pack_if.slave      bus
);

`ifdef FP_PACK_SAT_EN
    localparam logic [15:0] OVF_WORD = FP16_MAXF;
`else
    localparam logic [15:0] OVF_WORD = FP16_INF;
`endif

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic              s1_load, s2_load;
    logic [MANT_W-1:0] frac_rnd;
    logic [EXP_W:0]    exp_rnd;
    logic              ovf;

    // A stage may load when it is empty or its content leaves this cycle;
    // the ready chain is combinational from ready_i so a full pipe streams.
    assign s2_load     = !s2_valid_q || bus.ready_i;
    assign s1_load     = !s1_valid_q || s2_load;
    assign bus.ready_o = s1_load;

    assign s1_valid_d = s1_load ? bus.valid_i : s1_valid_q;
    assign s2_valid_d = s2_load ? s1_valid_q  : s2_valid_q;

    // Stage 1: split the magnitude into kept fraction, guard and sticky.
    always_comb begin
        s1_d          = '0;
        s1_d.sign     = bus.sign_i;
        s1_d.zero     = (bus.norm_data_i == '0);
        s1_d.exp_pre  = (EXP_W+1)'(EXP_BIAS) + {2'b00, bus.leading_bit_i};
        s1_d.frac_pre = bus.norm_data_i[14:5];
        s1_d.guard    = bus.norm_data_i[4];
        s1_d.sticky   = |bus.norm_data_i[3:0];
        // Exact tie rounds up only when the kept LSB is odd.
        s1_d.round_up = bus.norm_data_i[4] &
                        ((|bus.norm_data_i[3:0]) | bus.norm_data_i[5]);
    end

    fp_rne_round u_rne (
        .frac_pre_i (s1_q.frac_pre),
        .round_up_i (s1_q.round_up),
        .exp_pre_i  (s1_q.exp_pre),
        .frac_o     (frac_rnd),
        .exp_o      (exp_rnd)
    );

    // Only leading_bit 15 plus a rounding carry can reach EXP_MAX.
    assign ovf = !s1_q.zero && (exp_rnd >= (EXP_W+1)'(EXP_MAX));

    // Stage 2: assemble the binary16 word and flags.
    always_comb begin
        s2_d = '0;
        if (s1_q.zero) begin
            s2_d.fp = {s1_q.sign, 15'b0};
        end else if (ovf) begin
            s2_d.fp      = {s1_q.sign, OVF_WORD[14:0]};
            s2_d.inexact = 1'b1;
            s2_d.ovf     = 1'b1;
        end else begin
            s2_d.fp      = {s1_q.sign, exp_rnd[EXP_W-1:0], frac_rnd};
            s2_d.inexact = s1_q.guard | s1_q.sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load && bus.valid_i) begin
                s1_q <= s1_d;
            end
            if (s2_load && s1_valid_q) begin
                s2_q <= s2_d;
            end
        end
    end

    assign bus.valid_o   = s2_valid_q;
    assign bus.fp_data_o = s2_q.fp;
    assign bus.inexact_o = s2_q.inexact;
    assign bus.ovf_o     = s2_q.ovf;

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed bench for fp_round_pack with a value-level
// rounding model, an expected queue and a per-cycle output compare.
module tb_fp_round_pack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_round_pack_if bus ();

    fp_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] exp_q[$];          // {ovf, inexact, fp}
    logic        hold_pending = 1'b0;
    logic [17:0] held;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Value-level model: keep 11 significant bits, round the 5 dropped bits
    // to nearest even, renormalize on 2048, saturate/infinity past exp 30.
    function automatic logic [17:0] model(input logic s, input logic [15:0] n,
                                          input logic [3:0] lead);
        int m, rem, e;
        logic inx;
        if (n == 16'h0) return {2'b00, s, 15'b0};
        m   = int'(n) / 32;
        rem = int'(n) % 32;
        e   = 15 + int'(lead);
        inx = (rem != 0);
        if (rem > 16 || (rem == 16 && (m % 2) == 1)) m = m + 1;
        if (m == 2048) begin
            m = 1024;
            e = e + 1;
        end
        if (e >= 31) begin
`ifdef FP_PACK_SAT_EN
            return {2'b11, s, 15'h7BFF};
`else
            return {2'b11, s, 15'h7C00};
`endif
        end
        return {1'b0, inx, s, 5'(e), 10'(m - 1024)};
    endfunction

    // Compare process: sample away from the active edge.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(bus.valid_o), 32'd1);
                check("hold_data", 32'({bus.ovf_o, bus.inexact_o, bus.fp_data_o}), 32'(held));
            end
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_output: got %h with nothing expected at %0t",
                             bus.fp_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("fp_data", 32'(bus.fp_data_o), 32'(e[15:0]));
                    check("inexact", 32'(bus.inexact_o), 32'(e[16]));
                    check("ovf",     32'(bus.ovf_o),     32'(e[17]));
                end
            end
            if (bus.valid_i && bus.ready_o)
                exp_q.push_back(model(bus.sign_i, bus.norm_data_i, bus.leading_bit_i));
            hold_pending = bus.valid_o && !bus.ready_i;
            held         = {bus.ovf_o, bus.inexact_o, bus.fp_data_o};
        end
    end

    // Driver: present a word and hold it until accepted (bounded).
    task automatic send(input logic s, input logic [15:0] n, input logic [3:0] lead);
        int   t = 0;
        logic acc;
        bus.valid_i       = 1'b1;
        bus.sign_i        = s;
        bus.norm_data_i   = n;
        bus.leading_bit_i = lead;
        do begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    localparam int NV = 12;
    logic        v_s   [NV] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    logic [15:0] v_n   [NV] = '{16'h8000, 16'hC006, 16'h8010, 16'h8030, 16'hFFFF, 16'h0000,
                                16'h8000, 16'hFFFF, 16'h8000, 16'hFFEF, 16'hFFFF, 16'h8011};
    logic [3:0]  v_l   [NV] = '{0, 14, 11, 11, 15, 7, 0, 14, 15, 3, 15, 2};

    initial begin
        int lat;
        rst               = 1'b1;
        bus.valid_i       = 1'b0;
        bus.ready_i       = 1'b1;
        bus.sign_i        = 1'b0;
        bus.norm_data_i   = '0;
        bus.leading_bit_i = '0;

        // Hand-computed pins on the model itself.
        check("pin_one",      32'(model(0, 16'h8000, 0)),  32'h03C00);
        check("pin_trunc",    32'(model(0, 16'hC006, 14)), 32'h17600);
        check("pin_tie_even", 32'(model(0, 16'h8010, 11)), 32'h16800);
        check("pin_tie_up",   32'(model(0, 16'h8030, 11)), 32'h16802);
`ifdef FP_PACK_SAT_EN
        check("pin_ovf",      32'(model(0, 16'hFFFF, 15)), 32'h37BFF);
`else
        check("pin_ovf",      32'(model(0, 16'hFFFF, 15)), 32'h37C00);
`endif
        check("pin_neg_zero", 32'(model(1, 16'h0000, 9)),  32'h08000);
        check("pin_neg_one",  32'(model(1, 16'h8000, 0)),  32'h0BC00);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid_o", 32'(bus.valid_o),   32'd0);
        check("rst_fp",      32'(bus.fp_data_o), 32'd0);
        check("rst_inexact", 32'(bus.inexact_o), 32'd0);
        check("rst_ovf",     32'(bus.ovf_o),     32'd0);
        check("rst_ready_o", 32'(bus.ready_o),   32'd1);

        // Latency: valid_o appears on the second sample after the accept edge.
        send(0, 16'h8000, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.valid_o && lat < 10);
        check("latency", 32'(lat), 32'd2);
        check("lat_fp", 32'(bus.fp_data_o), 32'h3C00);
        @(posedge clk);
        #1;
        drain();

        // Directed vectors back to back at full throughput.
        for (int i = 0; i < NV; i++) send(v_s[i], v_n[i], v_l[i]);
        drain();

        // Same vectors with a pseudo-random consumer stall pattern.
        fork
            begin
                for (int i = 0; i < NV; i++) send(v_s[i], v_n[i], v_l[i]);
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1 bus.ready_i = 1'($urandom_range(0, 1));
                end
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Backpressure: two words fill the pipe, the third must wait.
        bus.ready_i = 1'b0;
        send(0, 16'h8000, 1);
        send(0, 16'h8030, 5);
        bus.valid_i       = 1'b1;
        bus.sign_i        = 1'b1;
        bus.norm_data_i   = 16'hC006;
        bus.leading_bit_i = 4'd6;
        @(negedge clk);
        check("ready_drop", 32'(bus.ready_o), 32'd0);
        check("stall_valid_o", 32'(bus.valid_o), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.ready_i = 1'b1;
        send(1, 16'hC006, 6);
        drain();

        // Reset with two words in flight: nothing from them may emerge.
        send(0, 16'h9000, 4);
        send(1, 16'hA000, 8);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
        check("midrst_ready_o", 32'(bus.ready_o), 32'd1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        send(0, 16'hFFFF, 15);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
